// File: rtl/imem_pkg.sv
// imem_pkg: shared types, default sizes and fetch-fault helper for the instruction memory.
package imem_pkg;
    typedef enum logic {RUN, LOAD} imem_state_t;

    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_DEPTH  = 4096;

    // Address is zero-extended to 64 bits so one helper serves every ADDR_W.
    function automatic logic imem_fault(input logic [63:0] addr, input int ofs, input longint unsigned depth);
        return ((addr & ((64'd1 << ofs) - 64'd1)) != 64'd0) || ((addr >> ofs) >= depth);
    endfunction
endpackage

// File: rtl/imem_sram.sv
// imem_sram: DEPTH x DATA_W single-port synchronous RAM, one read or one write per cycle.
module imem_sram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/instr_mem.sv
// instr_mem: synchronous instruction memory with valid/ready fetch port, fault flagging and program-load mode.
module instr_mem
    import imem_pkg::*;
#(
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int ADDR_W    = 32,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int BYTE_OFS = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic              loading
);
    imem_state_t       state, state_nx;
    logic              accept, fault, drain_ok, ram_en, ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        drain_ok  = !rsp_valid || rsp_ready;
        req_ready = state == RUN && !prog_en && drain_ok;
        accept    = req_valid && req_ready;
        fault     = imem_fault(64'(req_addr), BYTE_OFS, 64'(DEPTH));
        ram_we    = state == LOAD && prog_we;
        ram_en    = ram_we || (accept && !fault);
        ram_addr  = ram_we ? prog_addr : IDX_W'(req_addr >> BYTE_OFS);
        state_nx  = state == RUN ? ((prog_en && drain_ok) ? LOAD : RUN) : (prog_en ? LOAD : RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= accept || (rsp_valid && !rsp_ready);
            if (accept) rsp_err <= fault;
        end
    end

    // RAM output is not reset, so data is gated by the (reset) valid and error flags.
    assign rsp_data = (rsp_valid && !rsp_err) ? ram_rdata : '0;
    assign loading  = state == LOAD;

    imem_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (prog_wdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed test of instr_mem against a transaction-level memory model.
module tb_instr_mem;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_err, loading;
    logic [31:0] req_addr = '0, rsp_data, prog_wdata = '0;
    logic        prog_en = 1'b0, prog_we = 1'b0;
    logic [11:0] prog_addr = '0;
    int          total = 0, bad = 0;

    instr_mem dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .loading(loading)
    );

    always #5 clk = ~clk;

    // Model: word array, one outstanding response slot, load-mode flag.
    logic [31:0] mm [4096];
    logic        m_valid = 1'b0, m_err = 1'b0, m_load = 1'b0, m_ready;
    logic [31:0] m_data = '0;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 4096);
    endfunction

    assign m_ready = !m_load && !prog_en && (!m_valid || rsp_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_load  <= 1'b0;
        end else begin
            if (m_load) begin
                if (prog_we) mm[prog_addr] <= prog_wdata;
                if (!prog_en) m_load <= 1'b0;
            end else if (prog_en && (!m_valid || rsp_ready)) m_load <= 1'b1;
            if (m_ready && req_valid) begin
                m_valid <= 1'b1;
                m_err   <= addr_bad(req_addr);
                m_data  <= addr_bad(req_addr) ? 32'h0 : mm[req_addr / 4];
            end else if (rsp_ready) m_valid <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", req_ready, m_ready);
            chk("rsp_valid", rsp_valid, m_valid);
            chk("loading", loading, m_load);
            if (m_valid) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick();
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        tick();
    endtask

    initial begin
        tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_loading", loading, 0);
        rst_n = 1'b1;
        tick();
        prog_en = 1'b1;
        tick();
        chk("enter_load", loading, 1);
        wr(12'd0, 32'h00000293);
        wr(12'd1, 32'h00128293);
        wr(12'd2, 32'h00502023);
        wr(12'd4095, 32'hCAFEF00D);
        prog_we = 1'b0; prog_en = 1'b0;
        tick();
        chk("exit_load", loading, 0);
        // Back-to-back fetches, first one in the first RUN cycle.
        fetch(32'h0);
        chk("f0", rsp_data, 32'h00000293);
        fetch(32'h4);
        chk("f1", rsp_data, 32'h00128293);
        fetch(32'h8);
        chk("f2", rsp_data, 32'h00502023);
        chk("f2_err", rsp_err, 0);
        req_valid = 1'b0;
        tick();
        chk("idle_valid", rsp_valid, 0);
        // Backpressure.
        fetch(32'h4);
        req_addr = 32'h8; rsp_ready = 1'b0;
        #1 chk("bp_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", rsp_data, 32'h00128293);
            chk("bp_ready_hold", req_ready, 0);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release", req_ready, 1);
        tick();
        chk("bp_next", rsp_data, 32'h00502023);
        // Faults.
        fetch(32'h2);
        chk("mis_err", rsp_err, 1);
        chk("mis_data", rsp_data, 0);
        fetch(32'h4000);
        chk("oor_err", rsp_err, 1);
        fetch(32'h3FFC);
        chk("last_err", rsp_err, 0);
        chk("last_data", rsp_data, 32'hCAFEF00D);
        req_valid = 1'b0;
        tick();
        // Load request while a response is stalled; early write must be ignored.
        fetch(32'h0);
        req_valid = 1'b0; rsp_ready = 1'b0;
        prog_en = 1'b1; prog_we = 1'b1; prog_addr = 12'd0; prog_wdata = 32'hDEADBEEF;
        #1 chk("pend_ready", req_ready, 0);
        tick();
        chk("pend_load0", loading, 0);
        tick();
        chk("pend_load1", loading, 0);
        chk("pend_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        chk("pend_enter", loading, 1);
        wr(12'd5, 32'hFF5FF0EF);
        prog_we = 1'b0; prog_en = 1'b0;
        tick();
        fetch(32'h0);
        chk("ignored_we", rsp_data, 32'h00000293);
        // Asynchronous reset with a response pending.
        fetch(32'h14);
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("pre_rst", rsp_data, 32'hFF5FF0EF);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_data", rsp_data, 0);
        chk("arst_err", rsp_err, 0);
        chk("arst_loading", loading, 0);
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        fetch(32'h14);
        chk("persist", rsp_data, 32'hFF5FF0EF);
        req_valid = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
Parametrised, synchronous instruction memory for the RISC-V fetch stage; successor to the fixed 4096x32 combinational instruction ROM.
- Reads use a valid/ready request/response handshake with 1-cycle latency and full-throughput backpressure.
- Flags misaligned and out-of-range fetches.
- Provides a program-load port, so test images are written at runtime instead of being hard-coded.
- Sits between the fetch unit (request side) and the decode stage (response side).

Parameters:
- DATA_W, 32, instruction word width in bits; multiple of 8.
- DEPTH, 4096, number of words; power of two, at least 2.
- ADDR_W, 32, width of the fetch byte address.
- IDX_W, $clog2(DEPTH), word index width (derived; not overridden).
- BYTE_OFS, $clog2(DATA_W/8), low address bits that must be zero (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  fetched word; 0 when rsp_err=1.
- rsp_err  out  1  fetch fault: misaligned or out of range.
- prog_en  in  1  request program-load mode.
- prog_we  in  1  write strobe; honoured only in LOAD state.
- prog_addr  in  IDX_W  word index to write.
- prog_wdata  in  DATA_W  word to write.
- loading  out  1  high while in LOAD state.

Behaviour:
- Reset values (async, rst_n low): rsp_valid=0, rsp_data=0, rsp_err=0, state=RUN, loading=0.
  - Memory array is not reset; contents survive rst_n.
  - Reset mid-transaction discards any pending response.
- FSM states: RUN and LOAD.
  - RUN->LOAD when prog_en=1 and no response is pending (rsp_valid=0, or handshake completes this cycle).
  - LOAD->RUN when prog_en=0.
  - loading = (state==LOAD).
- req_ready = (state==RUN) && !prog_en && (!rsp_valid || rsp_ready). Combinational; pass-through bubble-free.
- Accepted request at cycle N gives rsp_valid=1 at N+1, with data registered from the array.
  - Back-to-back accepts give one response per cycle.
- rsp_valid falls only on the rsp_valid && rsp_ready handshake with no new accept in the same cycle.
- rsp_data and rsp_err are held stable while rsp_valid && !rsp_ready.
- Fault rules, evaluated at accept:
  - Misaligned: req_addr[BYTE_OFS-1:0] != 0.
  - Out of range: req_addr[ADDR_W-1:BYTE_OFS] >= DEPTH.
  - Either condition sets rsp_err=1 and rsp_data=0; no array read is used.
  - Otherwise rsp_err=0 and word index = req_addr[BYTE_OFS+IDX_W-1:BYTE_OFS].
- Writes: in LOAD, prog_we=1 writes prog_wdata to mem[prog_addr] at the clock edge. prog_we is ignored in RUN.
- Simultaneous events:
  - prog_en rising while a response is pending: the response drains normally, then LOAD is entered.
  - No new requests are accepted from the cycle prog_en is seen high.
- Read-after-write: a fetch accepted in the first RUN cycle after LOAD returns the newly written data.
- Memory is inferrable as single-port synchronous RAM (one read or one write per cycle, never both).

Decomposition:
- Package imem_pkg holds:
  - typedef enum logic {RUN, LOAD} imem_state_t
  - localparams for default DATA_W/DEPTH
  - function imem_fault(addr) returning the misaligned/out-of-range flag
- One natural sub-module, imem_sram: DEPTH x DATA_W single-port synchronous RAM with en, we, addr, wdata, rdata.
- instr_mem holds the FSM, handshake, fault logic and response register.

Test Plan:
- Reset: assert rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid=0, rsp_data=0, rsp_err=0 immediately (asynchronous); loading=0.
- Load then fetch:
  - Stimulus: prog_en=1; write 0x00000293, 0x00128293, 0x00502023 to indices 0..2; prog_en=0; requests at 0x0, 0x4, 0x8 on consecutive cycles, rsp_ready=1.
  - Required: 3 responses on consecutive cycles with those words, rsp_err=0.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 3 cycles after a fetch of 0x4.
  - Required: req_ready=0 and rsp_data=0x00128293 held stable; the next request is accepted in the same cycle rsp_ready rises.
- Faults:
  - Fetch 0x2 -> rsp_err=1, rsp_data=0.
  - Fetch 0x4000 (DEPTH=4096) -> rsp_err=1.
  - Fetch 0x3FFC -> rsp_err=0, returns mem[4095].
- Load during pending response:
  - Stimulus: assert prog_en while rsp_valid=1 and rsp_ready=0.
  - Required: loading stays 0 until the handshake; req_ready=0 throughout; prog_we ignored before LOAD is entered.
- Persistence:
  - Stimulus: write mem[5]=0xFF5FF0EF, pulse rst_n, fetch 0x14.
  - Required: 0xFF5FF0EF returned.
